s3ga_wb_master: RTL and testbench

S3GA_WB_MASTER -- requirements
Module: s3ga_wb_master

---
 rtl/s3ga_wb_master.sv | 221 ++++++++++++++++++++++
 tb/tb_s3ga_wb_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3ga_wb_master.sv
// s3ga_wb_master
//   Converts a valid/ready command into a single Wishbone classic read or
//   write cycle. It then returns the result on a valid/ready response port.
//   Only one transaction is outstanding at a time.
//
//   Build option: define S3GA_WBM_TIMEOUT_EN to enable the bus watchdog.
//   With the watchdog, a cycle that sees no wbm_ack_i for TIMEOUT_CYCLES
//   strobe cycles is aborted and reported with rsp_err = 1. Without the
//   watchdog, the block waits for ack indefinitely and rsp_err is tied to 0.
//
// Ports
//   wb_clk_i, wb_rst_ni             clock; async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_we/adr/dat/sel              command fields (1 = write)
//   rsp_valid/rsp_ready             response handshake
//   rsp_dat, rsp_err                read data (0 for writes/errors), timeout flag
//   wbm_cyc_o/stb_o/we_o            Wishbone initiator strobes
//   wbm_adr_o/dat_o/sel_o           Wishbone address/write data/byte selects
//   wbm_ack_i, wbm_dat_i            Wishbone acknowledge and read data
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, bus quiet, waiting for cmd_valid
// BUS   | cyc/stb asserted with the captured command, waiting for ack
// RESP  | response presented, waiting for rsp_ready

module s3ga_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("s3ga_wb_master: TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

`ifdef S3GA_WBM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef S3GA_WBM_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q gates acceptance so that nothing is taken before
        // the first clock edge after reset release.
        if (cmd_ready_q && cmd_valid) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
`ifdef S3GA_WBM_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end

      ST_BUS: begin
        if (wbm_ack_i) begin
          // Ack wins over a simultaneous timeout.
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          sel_d       = 4'd0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
`ifdef S3GA_WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef S3GA_WBM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          sel_d       = 4'd0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'd0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = 32'd0;
`ifdef S3GA_WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      sel_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
`ifdef S3GA_WBM_TIMEOUT_EN
      cnt_q       <= 16'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef S3GA_WBM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

`ifdef S3GA_WBM_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_s3ga_wb_master.sv
module tb_s3ga_wb_master;

`ifdef S3GA_WBM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int checks = 0;
  int errors = 0;

  s3ga_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // One complete transaction. Called at a negedge; returns at a negedge in
  // IDLE. The expected behaviour is derived from the transaction-level
  // rules: strobe lasts until ack or until the watchdog limit, and the
  // response carries read data only for acked reads.
  task automatic do_txn(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int ack_delay, input logic [31:0] ack_dat,
                        input int rsp_delay, input bit hold_ack,
                        input string tag);
    int          n;
    int          w;
    bit          exp_err;
    logic [31:0] exp_dat;
    logic [72:0] got73, exp73;
    logic [36:0] got37, exp37;
    exp_err = TO_EN && (ack_delay >= TO);
    n       = exp_err ? TO : ack_delay + 1;
    exp_dat = (we || exp_err) ? 32'd0 : ack_dat;

    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      @(negedge wb_clk_i);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL %s cmd_ready_wait: got %b expected 1", tag, cmd_ready);
      errors++;
      return;
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_we = $urandom_range(0, 1); cmd_adr = $urandom; cmd_dat = $urandom;
    cmd_sel = 4'($urandom);

    for (int k = 0; k < n; k++) begin
      got73 = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
               rsp_valid, cmd_ready};
      exp73 = {1'b1, 1'b1, we, adr, dat, sel, 1'b0, 1'b0};
      checks++;
      if (got73 !== exp73) begin
        $display("FAIL %s bus_cycle%0d: got %h expected %h", tag, k, got73, exp73);
        errors++;
      end
      wbm_ack_i = (k == ack_delay);
      wbm_dat_i = (k == ack_delay) ? ack_dat : $urandom;
      @(negedge wb_clk_i);
    end

    for (int r = 0; r <= rsp_delay; r++) begin
      got37 = {rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, cmd_ready};
      exp37 = {1'b1, exp_dat, exp_err, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got37 !== exp37) begin
        $display("FAIL %s resp_cycle%0d: got %h expected %h", tag, r, got37, exp37);
        errors++;
      end
      rsp_ready = (r == rsp_delay);
      wbm_ack_i = hold_ack ? 1'b1 : 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
    end

    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    got73 = {rsp_valid, cmd_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o,
             wbm_dat_o, wbm_sel_o};
    exp73 = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    checks++;
    if (got73 !== exp73) begin
      $display("FAIL %s back_to_idle: got %h expected %h", tag, got73, exp73);
      errors++;
    end
  endtask

  task automatic test_reset();
    logic [72:0] got;
    wb_rst_ni = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    #2;
    got = {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_adr_o, wbm_dat_o, wbm_sel_o};
    checks++;
    if (got !== 73'd0) begin
      $display("FAIL reset_values: got %h expected 0", got);
      errors++;
    end
    checks++;
    if (rsp_dat !== 32'd0) begin
      $display("FAIL reset_rsp_dat: got %h expected 0", rsp_dat);
      errors++;
    end
    cmd_valid = 1'b1; wbm_ack_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if ({cmd_ready, wbm_stb_o, rsp_valid} !== 3'b000) begin
      $display("FAIL reset_held: got %b expected 000", {cmd_ready, wbm_stb_o, rsp_valid});
      errors++;
    end
    cmd_valid = 1'b0; wbm_ack_i = 1'b0;
    wb_rst_ni = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL ready_before_edge: got %b expected 0", cmd_ready);
      errors++;
    end
    @(negedge wb_clk_i);
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL ready_after_edge: got %b expected 1", cmd_ready);
      errors++;
    end
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 4; i++) begin
      wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0001) begin
        $display("FAIL idle_ack%0d: got %b expected 0001", i,
                 {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready});
        errors++;
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_write();
    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h1111_2222, 0, 1'b0, "write");
  endtask

  task automatic test_read();
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0, 1'b0, "read");
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 5, 1'b0, "backpressure");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h1, 0, 32'h0BAD_CAFE, 0, 1'b1, "b2b_0");
    do_txn(1'b1, 32'h0000_0104, 32'h1234_5678, 4'hC, 0, 32'hFFFF_FFFF, 0, 1'b1, "b2b_1");
    do_txn(1'b0, 32'h0000_0108, 32'h0, 4'hF, 0, 32'h0000_0001, 0, 1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4000_0000; cmd_sel = 4'hF;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    checks++;
    if (wbm_stb_o !== 1'b1) begin
      $display("FAIL midbus_stb_first: got %b expected 1", wbm_stb_o);
      errors++;
    end
    @(posedge wb_clk_i);
    #2 wb_rst_ni = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin
      $display("FAIL midbus_async: got %b expected 0000",
               {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready});
      errors++;
    end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_AAAA;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      checks++;
      if ({rsp_valid, wbm_stb_o} !== 2'b00) begin
        $display("FAIL midbus_after%0d: got %b expected 00", i, {rsp_valid, wbm_stb_o});
        errors++;
      end
    end
    do_txn(1'b0, 32'h4000_0008, 32'h0, 4'hF, 1, 32'h7777_8888, 0, 1'b0, "after_reset");

    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4000_000C; cmd_sel = 4'hF;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h9999_0000;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL midresp_valid: got %b expected 1", rsp_valid);
      errors++;
    end
    wb_rst_ni = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_dat} !== 33'd0) begin
      $display("FAIL midresp_async: got %h expected 0", {rsp_valid, rsp_dat});
      errors++;
    end
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      checks++;
      if (rsp_valid !== 1'b0) begin
        $display("FAIL midresp_after%0d: got %b expected 0", i, rsp_valid);
        errors++;
      end
    end
    rsp_ready = 1'b0;
  endtask

`ifdef S3GA_WBM_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 1000, 32'h1357_9BDF, 0, 1'b0, "timeout");
    do_txn(1'b0, 32'h5000_0004, 32'h0, 4'hF, TO - 1, 32'h2468_ACE0, 0, 1'b0, "ack_on_limit");
    do_txn(1'b1, 32'h5000_0008, 32'hFFFF_0000, 4'h6, TO, 32'h0, 1, 1'b0, "timeout_write");
  endtask
`else
  task automatic test_no_timeout();
    do_txn(1'b0, 32'h6000_0000, 32'h0, 4'hF, 1000, 32'hFEED_FACE, 0, 1'b0, "long_wait");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 6), $urandom, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
`ifdef S3GA_WBM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
